wdg_reset_ctrl: RTL and testbench
=================================

Name: wdg_reset_ctrl

Overview:
Reset controller directly downstream of the independent watchdog. It consumes the watchdog's level reset request and a software reset pulse, and drives a stretched, glitch-free core reset. It also records sticky reset-cause flags and a saturating count of reset events. It sits between the watchdog and the core/peripheral reset tree.

Parameters:
HOLD_CYCLES, 16, minimum number of cycles core_rst stays asserted per event; legal range 1..65535.
CNT_W, 8, width of the reset-event counter.

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
sys_rst  input  1  synchronous, active-high reset.
wdg_rst_req  input  1  watchdog reset request, level, active-high, synchronous to sys_clk.
sw_rst_req  input  1  software reset request, active-high; only rising edges matter.
cause_clr  input  1  one-cycle strobe; clears rst_cause.
core_rst  output  1  stretched reset to core, active-high.
rst_done  output  1  one-cycle pulse on the first IDLE cycle after a reset sequence.
rst_cause  output  3  sticky flags {sw, wdg, por}.
rst_count  output  CNT_W  number of watchdog/software reset entries, saturating.

Behaviour:
- States: IDLE, ASSERT, WAIT_RELEASE. The design is a Moore machine: core_rst = (state != IDLE) and comes straight from the state register.
- Edge detect: wdg_q and sw_q register the inputs; both reset to 0.
  - wdg_edge = wdg_rst_req & ~wdg_q.
  - sw_edge = sw_rst_req & ~sw_q.
- sys_rst high:
  - state <= ASSERT; hold_cnt <= HOLD_CYCLES-1; core_rst = 1.
  - rst_cause <= 3'b001 (por); rst_count <= 0; rst_done <= 0; wdg_q, sw_q <= 0.
- Power-on stretch: after sys_rst falls, core_rst stays high for exactly HOLD_CYCLES further cycles, plus any WAIT_RELEASE time.
- IDLE: on wdg_edge or sw_edge at a rising edge, state <= ASSERT and hold_cnt <= HOLD_CYCLES-1. core_rst is high from that same edge, giving 1-cycle latency from request to core_rst.
- ASSERT:
  - hold_cnt decrements each cycle.
  - When hold_cnt == 0: if wdg_rst_req | sw_rst_req, go to WAIT_RELEASE; otherwise go to IDLE.
  - ASSERT lasts exactly HOLD_CYCLES cycles.
  - New edges during ASSERT do not restart hold_cnt; they do set cause flags.
- WAIT_RELEASE: stays until wdg_rst_req == 0 and sw_rst_req == 0 in the same cycle, then goes to IDLE.
- rst_done: registered; high for one cycle in the first cycle state == IDLE following ASSERT or WAIT_RELEASE. It is never high while core_rst is high.
- rst_cause:
  - wdg bit set on any wdg_edge in any state; sw bit set on any sw_edge in any state.
  - cause_clr clears all three bits.
  - If a set and cause_clr coincide, the set wins for that bit; other bits clear.
- rst_count: increments by 1 on each IDLE->ASSERT transition. It saturates at 2^CNT_W-1 (no wrap) and is not cleared by cause_clr.
- Simultaneous wdg_edge and sw_edge: one entry into ASSERT, count +1, both cause bits set.
- Request held high continuously produces no re-trigger; a new edge requires the input to fall and rise again.

Test Plan:
- Power-on, HOLD_CYCLES=16: sys_rst high 3 cycles, then low with requests low -> core_rst high for 16 cycles after release; rst_done pulses on cycle 17; rst_cause=3'b001; rst_count=0.
- From IDLE, wdg_rst_req pulses 1 cycle -> core_rst rises 1 edge later and lasts 16 cycles; rst_cause=3'b011; rst_count=1; one rst_done pulse.
- wdg_rst_req held high 40 cycles -> core_rst stays high through WAIT_RELEASE; it drops one edge after the request falls; count +1 only.
- wdg and sw rise in the same cycle -> single 16-cycle assertion; rst_cause bits {sw,wdg}=11; count +1. Then cause_clr coinciding with a new sw_edge -> rst_cause=3'b100.
- CNT_W=2, five separate sw pulses spaced 30 cycles apart -> rst_count reads 1,2,3,3,3.
- sys_rst asserted at ASSERT cycle 8 of a watchdog sequence -> restart as power-on: rst_cause=3'b001, rst_count=0, full 16-cycle hold after release, no rst_done during the reset.

Source files
------------

// File: rtl/wdg_reset_ctrl.sv
// Reset controller fed by the independent watchdog and a software reset pulse.
// Produces a stretched core reset, a one-cycle completion pulse, sticky
// reset-cause flags {sw, wdg, por} and a saturating count of reset entries.
module wdg_reset_ctrl #(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             wdg_rst_req,
    input  logic             sw_rst_req,
    input  logic             cause_clr,
    output logic             core_rst,
    output logic             rst_done,
    output logic [2:0]       rst_cause,
    output logic [CNT_W-1:0] rst_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_RELEASE
    } state_t;

    localparam logic [15:0]      HOLD_INIT = 16'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            r_state;
    state_t            w_nextState;
    logic [15:0]       r_holdCnt;
    logic [15:0]       w_nextHoldCnt;
    logic              r_wdgQ;
    logic              r_swQ;
    logic              r_done;
    logic [2:0]        r_cause;
    logic [CNT_W-1:0]  r_count;
    logic              w_wdgEdge;
    logic              w_swEdge;
    logic              w_anyReq;
    logic              w_enterAssert;

    assign w_wdgEdge = wdg_rst_req & ~r_wdgQ;
    assign w_swEdge  = sw_rst_req & ~r_swQ;
    assign w_anyReq  = wdg_rst_req | sw_rst_req;

    // State and hold counter; reset re-enters ASSERT so power-on gets a full stretch
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_ASSERT;
            r_holdCnt <= HOLD_INIT;
        end else begin
            r_state   <= w_nextState;
            r_holdCnt <= w_nextHoldCnt;
        end
    end

    // Next-state logic: edges only trigger from IDLE, ASSERT runs its full hold
    always_comb begin
        w_nextState   = r_state;
        w_nextHoldCnt = r_holdCnt;
        w_enterAssert = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wdgEdge || w_swEdge) begin
                    w_nextState   = ST_ASSERT;
                    w_nextHoldCnt = HOLD_INIT;
                    w_enterAssert = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (r_holdCnt == 16'd0) begin
                    w_nextState = w_anyReq ? ST_WAIT_RELEASE : ST_IDLE;
                end else begin
                    w_nextHoldCnt = r_holdCnt - 16'd1;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!w_anyReq) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Input history for rising-edge detection of both request sources
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wdgQ <= 1'b0;
            r_swQ  <= 1'b0;
        end else begin
            r_wdgQ <= wdg_rst_req;
            r_swQ  <= sw_rst_req;
        end
    end

    // Completion pulse lands in the first IDLE cycle after a reset sequence
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state != ST_IDLE) && (w_nextState == ST_IDLE);
        end
    end

    // Sticky cause flags; a coincident set beats the clear for its own bit
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cause <= 3'b001;
        end else if (cause_clr) begin
            r_cause <= {w_swEdge, w_wdgEdge, 1'b0};
        end else begin
            r_cause <= r_cause | {w_swEdge, w_wdgEdge, 1'b0};
        end
    end

    // Saturating count of IDLE->ASSERT entries, untouched by cause_clr
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_count <= '0;
        end else if (w_enterAssert && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign core_rst  = (r_state != ST_IDLE);
    assign rst_done  = r_done;
    assign rst_cause = r_cause;
    assign rst_count = r_count;

endmodule

// File: tb/tb_wdg_reset_ctrl.sv
// Self-checking bench for wdg_reset_ctrl: per-cycle core_rst/rst_done
// expectations go through a scoreboard queue; cause and count are checked inline.
module tb_wdg_reset_ctrl;

    localparam int HOLD = 16;

    typedef struct packed {
        logic core;
        logic done;
    } exp_t;

    logic       clk = 1'b0;
    logic       sysRst = 1'b0;
    logic       wdgReq = 1'b0;
    logic       swReq = 1'b0;
    logic       causeClr = 1'b0;
    logic       coreRst;
    logic       rstDone;
    logic [2:0] rstCause;
    logic [7:0] rstCount;
    logic       coreRst2;
    logic       rstDone2;
    logic [2:0] rstCause2;
    logic [1:0] rstCount2;

    exp_t sbQ[$];
    exp_t e;
    int   testsRun = 0;
    int   failCount = 0;
    int   expCount = 0;

    wdg_reset_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
        .sys_clk(clk), .sys_rst(sysRst), .wdg_rst_req(wdgReq), .sw_rst_req(swReq),
        .cause_clr(causeClr), .core_rst(coreRst), .rst_done(rstDone),
        .rst_cause(rstCause), .rst_count(rstCount)
    );

    wdg_reset_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(2)) dutSmall (
        .sys_clk(clk), .sys_rst(sysRst), .wdg_rst_req(wdgReq), .sw_rst_req(swReq),
        .cause_clr(causeClr), .core_rst(coreRst2), .rst_done(rstDone2),
        .rst_cause(rstCause2), .rst_count(rstCount2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        sysRst = 1'b1;
        wdgReq = 1'b0;
        swReq = 1'b0;
        causeClr = 1'b0;
        repeat (3) tick();
        testsRun++;
        if (coreRst !== 1'b1 || rstDone !== 1'b0 || rstCause !== 3'b001 || rstCount !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL reset_state: core=%b done=%b cause=%b count=%0d expected core=1 done=0 cause=001 count=0",
                     coreRst, rstDone, rstCause, rstCount);
        end
        sysRst = 1'b0;
        for (int k = 1; k <= HOLD + 2; k++) begin
            sbQ.push_back('{core: (k < HOLD), done: (k == HOLD)});
            tick();
            e = sbQ.pop_front();
            testsRun++;
            if (coreRst !== e.core || rstDone !== e.done) begin
                failCount++;
                $display("[TB] FAIL poweron_trace k=%0d: core=%b done=%b expected core=%b done=%b",
                         k, coreRst, rstDone, e.core, e.done);
            end
        end
        expCount = 0;
        testsRun++;
        if (rstCause !== 3'b001 || rstCount !== 8'(expCount)) begin
            failCount++;
            $display("[TB] FAIL poweron_flags: cause=%b count=%0d expected cause=001 count=0", rstCause, rstCount);
        end
    endtask

    task automatic test_wdg_pulse();
        for (int k = 1; k <= HOLD + 2; k++) begin
            wdgReq = (k == 1);
            sbQ.push_back('{core: (k <= HOLD), done: (k == HOLD + 1)});
            tick();
            e = sbQ.pop_front();
            testsRun++;
            if (coreRst !== e.core || rstDone !== e.done) begin
                failCount++;
                $display("[TB] FAIL wdg_pulse_trace k=%0d: core=%b done=%b expected core=%b done=%b",
                         k, coreRst, rstDone, e.core, e.done);
            end
        end
        wdgReq = 1'b0;
        expCount++;
        testsRun++;
        if (rstCause !== 3'b011 || rstCount !== 8'(expCount)) begin
            failCount++;
            $display("[TB] FAIL wdg_pulse_flags: cause=%b count=%0d expected cause=011 count=%0d",
                     rstCause, rstCount, expCount);
        end
    endtask

    task automatic test_wdg_held();
        for (int k = 1; k <= 43; k++) begin
            wdgReq = (k <= 40);
            sbQ.push_back('{core: (k <= 40), done: (k == 41)});
            tick();
            e = sbQ.pop_front();
            testsRun++;
            if (coreRst !== e.core || rstDone !== e.done) begin
                failCount++;
                $display("[TB] FAIL wdg_held_trace k=%0d: core=%b done=%b expected core=%b done=%b",
                         k, coreRst, rstDone, e.core, e.done);
            end
        end
        expCount++;
        testsRun++;
        if (rstCount !== 8'(expCount)) begin
            failCount++;
            $display("[TB] FAIL wdg_held_count: count=%0d expected %0d", rstCount, expCount);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 1; k <= HOLD + 2; k++) begin
            wdgReq = (k == 1);
            swReq = (k == 1);
            sbQ.push_back('{core: (k <= HOLD), done: (k == HOLD + 1)});
            tick();
            e = sbQ.pop_front();
            testsRun++;
            if (coreRst !== e.core || rstDone !== e.done) begin
                failCount++;
                $display("[TB] FAIL simul_trace k=%0d: core=%b done=%b expected core=%b done=%b",
                         k, coreRst, rstDone, e.core, e.done);
            end
        end
        expCount++;
        testsRun++;
        if (rstCause !== 3'b111 || rstCount !== 8'(expCount)) begin
            failCount++;
            $display("[TB] FAIL simul_flags: cause=%b count=%0d expected cause=111 count=%0d",
                     rstCause, rstCount, expCount);
        end
    endtask

    task automatic test_cause_clr();
        swReq = 1'b1;
        causeClr = 1'b1;
        tick();
        swReq = 1'b0;
        causeClr = 1'b0;
        expCount++;
        testsRun++;
        if (rstCause !== 3'b100 || coreRst !== 1'b1 || rstCount !== 8'(expCount)) begin
            failCount++;
            $display("[TB] FAIL cause_clr_set_wins: cause=%b core=%b count=%0d expected cause=100 core=1 count=%0d",
                     rstCause, coreRst, rstCount, expCount);
        end
        repeat (HOLD + 2) tick();
        causeClr = 1'b1;
        tick();
        causeClr = 1'b0;
        testsRun++;
        if (rstCause !== 3'b000 || rstCount !== 8'(expCount)) begin
            failCount++;
            $display("[TB] FAIL cause_clr_plain: cause=%b count=%0d expected cause=000 count=%0d",
                     rstCause, rstCount, expCount);
        end
    endtask

    task automatic test_sysrst_mid();
        for (int k = 1; k <= 10; k++) begin
            wdgReq = (k == 1);
            sysRst = (k >= 9);
            sbQ.push_back('{core: 1'b1, done: 1'b0});
            tick();
            e = sbQ.pop_front();
            testsRun++;
            if (coreRst !== e.core || rstDone !== e.done) begin
                failCount++;
                $display("[TB] FAIL midrst_pre k=%0d: core=%b done=%b expected core=%b done=%b",
                         k, coreRst, rstDone, e.core, e.done);
            end
        end
        expCount = 0;
        testsRun++;
        if (rstCause !== 3'b001 || rstCount !== 8'(expCount)) begin
            failCount++;
            $display("[TB] FAIL midrst_flags: cause=%b count=%0d expected cause=001 count=0", rstCause, rstCount);
        end
        sysRst = 1'b0;
        for (int k = 1; k <= HOLD + 2; k++) begin
            sbQ.push_back('{core: (k < HOLD), done: (k == HOLD)});
            tick();
            e = sbQ.pop_front();
            testsRun++;
            if (coreRst !== e.core || rstDone !== e.done) begin
                failCount++;
                $display("[TB] FAIL midrst_post k=%0d: core=%b done=%b expected core=%b done=%b",
                         k, coreRst, rstDone, e.core, e.done);
            end
        end
    endtask

    task automatic test_count_saturate();
        int expSmall;
        sysRst = 1'b1;
        repeat (2) tick();
        sysRst = 1'b0;
        repeat (HOLD + 2) tick();
        expCount = 0;
        for (int p = 1; p <= 5; p++) begin
            swReq = 1'b1;
            tick();
            swReq = 1'b0;
            repeat (29) tick();
            expCount++;
            expSmall = (p < 3) ? p : 3;
            testsRun++;
            if (rstCount2 !== 2'(expSmall) || rstCount !== 8'(expCount)) begin
                failCount++;
                $display("[TB] FAIL count_sat p=%0d: small=%0d wide=%0d expected small=%0d wide=%0d",
                         p, rstCount2, rstCount, expSmall, expCount);
            end
        end
        testsRun++;
        if (rstCause2 !== 3'b101 || coreRst2 !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL count_sat_flags: cause=%b core=%b expected cause=101 core=0", rstCause2, coreRst2);
        end
    endtask

    initial begin
        test_reset();
        test_wdg_pulse();
        test_wdg_held();
        test_simultaneous();
        test_cause_clr();
        test_sysrst_mid();
        test_count_saturate();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
